// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search block:
// state encoding, default word width and the index-width helper.
package sar_pkg;

    localparam int SAR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2
    } sar_state_e;

    // Number of bits needed to hold an index in the range 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/sar_ugt_search_step.sv
// Combinational next-trial logic for one approximation step.
// kept       : trial with the bit under test cleared when the comparator says
//              the trial overshoots (trial > target), otherwise unchanged.
// next_trial : kept with the next-lower bit set, ready for the following step.
module sar_step
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic [WIDTH-1:0] trial,
    input  logic [WIDTH-1:0] mask,
    input  logic             gt,
    output logic [WIDTH-1:0] kept,
    output logic [WIDTH-1:0] next_trial
);

    // Decide the bit under test and seed the next one.
    always_comb begin
        kept       = gt ? (trial & ~mask) : trial;
        next_trial = kept | (mask >> 1);
    end

endmodule

// File: rtl/sar_ugt_search.sv
// Successive-approximation controller driving an external unsigned
// greater-than comparator (gt = trial > target). Resolves one bit per step,
// MSB first, and reports the recovered value on result with a one-cycle done.
// Build option: define SAR_SETTLE_EN to insert one SETTLE cycle after every
// trial update, so a registered or slow comparator can be used.
module sar_ugt_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int             IDX_W   = clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB    = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_e       state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [WIDTH-1:0] trial_n, result_n;
    logic             done_n;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] kept;
    logic [WIDTH-1:0] next_trial;

    // Bit currently under test.
    assign mask = {{(WIDTH-1){1'b0}}, 1'b1} << idx;

    sar_step #(.WIDTH(WIDTH)) u_step (
        .trial      (trial),
        .mask       (mask),
        .gt         (gt),
        .kept       (kept),
        .next_trial (next_trial)
    );

    // Next-state and next-register values for the conversion FSM.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a value unassigned and no latch is inferred.
        state_n  = state;
        idx_n    = idx;
        trial_n  = trial;
        result_n = result;
        done_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    trial_n = MSB;
                    idx_n   = IDX_TOP;
`ifdef SAR_SETTLE_EN
                    state_n = ST_SETTLE;
`else
                    state_n = ST_STEP;
`endif
                end
            end
            ST_STEP: begin
                if (idx == '0) begin
                    result_n = kept;
                    trial_n  = '0;
                    idx_n    = IDX_TOP;
                    done_n   = 1'b1;
                    state_n  = ST_IDLE;
                end else begin
                    trial_n = next_trial;
                    idx_n   = idx - 1'b1;
`ifdef SAR_SETTLE_EN
                    state_n = ST_SETTLE;
`else
                    state_n = ST_STEP;
`endif
                end
            end
`ifdef SAR_SETTLE_EN
            ST_SETTLE: begin
                // Comparator answer is still settling; gt is not looked at.
                state_n = ST_STEP;
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= IDX_TOP;
            trial  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its input from the same pre-edge values.
            state  <= state_n;
            idx    <= idx_n;
            trial  <= trial_n;
            result <= result_n;
            done   <= done_n;
        end
    end

    // Busy for the whole conversion, including any settle cycles.
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sar_ugt_search.sv
// Self-checking bench for sar_ugt_search (WIDTH=8). The comparator is
// modelled as gt = (trial > target): combinational in the default build,
// registered when SAR_SETTLE_EN is defined, with glitches forced onto gt
// during settle cycles.
`timescale 1ns/1ps
module tb_sar_ugt_search;

    localparam int WIDTH = 8;
`ifdef SAR_SETTLE_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif
    localparam int LAT = STRIDE * WIDTH;

    logic             clk;
    logic             reset;
    logic             start;
    logic             gt;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] target;
    logic             cmp;
    logic             glitch;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] exp_result;
        string            name;
    } vec_t;

    vec_t vecs[8];
    logic [WIDTH-1:0] seq_a5[8];

    sar_ugt_search #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .gt     (gt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SAR_SETTLE_EN
    always @(posedge clk or posedge reset) begin
        if (reset) cmp <= 1'b0;
        else       cmp <= (trial > target);
    end
`else
    assign cmp = (trial > target);
`endif
    assign gt = glitch ? ~cmp : cmp;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion. check_seq compares trial against seq_a5;
    // repulse_at >= 0 raises start again for one cycle after that edge.
    task automatic convert(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] exp,
                           input string name, input bit check_seq, input int repulse_at);
        target = tgt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({name, " busy@accept"}, 16'(busy), 16'd1);
        check({name, " trial@accept"}, 16'(trial), 16'(8'h80));
`ifdef SAR_SETTLE_EN
        glitch = 1'b1;
`endif
        for (int e = 1; e <= LAT; e++) begin
            tick();
`ifdef SAR_SETTLE_EN
            glitch = (e % 2 == 0) && (e < LAT);
`endif
            if (e == repulse_at)     start = 1'b1;
            if (e == repulse_at + 1) start = 1'b0;
            if (e < LAT) begin
                check({name, " done-early"}, 16'(done), 16'd0);
                if (check_seq && (e % STRIDE == 0))
                    check({name, " trial-seq"}, 16'(trial), 16'(seq_a5[e / STRIDE]));
            end else begin
                check({name, " done"}, 16'(done), 16'd1);
                check({name, " result"}, 16'(result), 16'(exp));
                check({name, " busy@done"}, 16'(busy), 16'd0);
                check({name, " trial@done"}, 16'(trial), 16'd0);
            end
        end
        start  = 1'b0;
        glitch = 1'b0;
        tick();
        check({name, " done-pulse"}, 16'(done), 16'd0);
        check({name, " result-hold"}, 16'(result), 16'(exp));
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        glitch = 1'b0;
        target = '0;

        seq_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vecs[0] = '{8'hA5, 8'hA5, "t_a5"};
        vecs[1] = '{8'h00, 8'h00, "t_zero"};
        vecs[2] = '{8'hFF, 8'hFF, "t_ones"};
        vecs[3] = '{8'h5A, 8'h5A, "t_5a"};
        vecs[4] = '{8'h01, 8'h01, "t_01"};
        vecs[5] = '{8'h80, 8'h80, "t_80"};
        vecs[6] = '{8'h7F, 8'h7F, "t_7f"};
        vecs[7] = '{8'h3C, 8'h3C, "t_3c"};

        // Reset values.
        #12;
        check("rst trial", 16'(trial), 16'd0);
        check("rst busy", 16'(busy), 16'd0);
        check("rst done", 16'(done), 16'd0);
        check("rst result", 16'(result), 16'd0);
        tick();
        reset = 1'b0;
        tick();

        // gt toggling while idle must not start anything.
        glitch = 1'b1;
        tick();
        tick();
        check("idle gt ignored busy", 16'(busy), 16'd0);
        glitch = 1'b0;

        // Table of single conversions; the first one also checks the trial walk.
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].target, vecs[i].exp_result, vecs[i].name, (i == 0), -1);
        end

        // start held high: each DONE cycle's start is accepted on its closing
        // edge, and every conversion takes LAT edges from that accept.
        target = 8'h3C;
        start  = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            for (int e = 1; e <= LAT; e++) begin
                tick();
                if (e < LAT) check("b2b done-early", 16'(done), 16'd0);
            end
            check("b2b done", 16'(done), 16'd1);
            check("b2b result", 16'(result), 16'(8'h3C));
            if (c == 2) start = 1'b0;
            tick();
            check("b2b done-pulse", 16'(done), 16'd0);
            check("b2b busy", 16'(busy), (c < 2) ? 16'd1 : 16'd0);
            if (c < 2) check("b2b trial restart", 16'(trial), 16'(8'h80));
        end

        // start re-pulsed mid-conversion is ignored.
        convert(8'hA5, 8'hA5, "repulse", 1'b1, 3 * STRIDE);

        // Asynchronous reset in the middle of a conversion.
        target = 8'h96;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int e = 1; e <= 4 * STRIDE; e++) tick();
        check("pre-abort busy", 16'(busy), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort trial", 16'(trial), 16'd0);
        check("abort busy", 16'(busy), 16'd0);
        check("abort done", 16'(done), 16'd0);
        check("abort result", 16'(result), 16'd0);
        tick();
        reset = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) begin
            tick();
            check("abort no-done", 16'(done), 16'd0);
        end
        convert(8'h96, 8'h96, "after-abort", 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
